// File: rtl/lcd_pkg.sv
// Shared opcodes, image geometry and sequencer state encoding
// for the LCD host-side command sequencer.
package lcd_pkg;

   localparam logic [3:0] CMD_WRITE = 4'd0;
   localparam logic [3:0] CMD_UP    = 4'd1;
   localparam logic [3:0] CMD_DOWN  = 4'd2;
   localparam logic [3:0] CMD_LEFT  = 4'd3;
   localparam logic [3:0] CMD_RIGHT = 4'd4;
   localparam logic [3:0] CMD_MAXOP = 4'd5;
   localparam logic [3:0] CMD_MIN   = 4'd6;
   localparam logic [3:0] CMD_AVG   = 4'd7;
   localparam logic [3:0] CMD_CCWR  = 4'd8;
   localparam logic [3:0] CMD_CWR   = 4'd9;
   localparam logic [3:0] CMD_MX    = 4'd10;
   localparam logic [3:0] CMD_MY    = 4'd11;
   localparam logic [3:0] CMD_MAX   = 4'd11;

   localparam int IMG_W   = 8;
   localparam int IMG_PIX = 64;

   typedef enum logic [2:0] {
      S_WAIT_RDY,
      S_ISSUE,
      S_GAP,
      S_WAIT_DONE,
      S_FINISHED
   } state_e;

   function automatic logic is_legal(input logic [3:0] op);
      return op <= CMD_MAX;
   endfunction

endpackage

// File: rtl/lcd_host_seq_if.sv
// Bundle of the upstream queue, controller command, IRAM capture
// and readback signals of the LCD host sequencer.
interface lcd_host_seq_if #(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 6
);
   logic [3:0]        in_cmd;
   logic              in_valid;
   logic              in_ready;
   logic              illegal_cmd;
   logic [3:0]        cmd;
   logic              cmd_valid;
   logic              busy;
   logic              done;
   logic              IRAM_valid;
   logic [ADDR_W-1:0] IRAM_A;
   logic [PIX_W-1:0]  IRAM_D;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_data;
   logic [6:0]        pix_cnt;
   logic              frame_done;

   modport master (
      input  in_cmd, in_valid, busy, done,
      input  IRAM_valid, IRAM_A, IRAM_D, rd_addr,
      output in_ready, illegal_cmd, cmd, cmd_valid,
      output rd_data, pix_cnt, frame_done
   );

   modport slave (
      output in_cmd, in_valid, busy, done,
      output IRAM_valid, IRAM_A, IRAM_D, rd_addr,
      input  in_ready, illegal_cmd, cmd, cmd_valid,
      input  rd_data, pix_cnt, frame_done
   );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous opcode FIFO; storage is not reset, pointers are.
module lcd_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/lcd_host_seq.sv
// Host sequencer: queues opcodes, paces issue to the LCD controller,
// captures the IRAM write-out into a local frame store.
module lcd_host_seq
   import lcd_pkg::*;
#(
   parameter int CMD_DEPTH = 8,
   parameter int PIX_W     = 8,
   parameter int ADDR_W    = 6
) (
   input logic clk,
   input logic reset,
   lcd_host_seq_if.master bus
);
   localparam int NPIX = 2 ** ADDR_W;

   state_e          state_q, state_d;
   logic [3:0]      cmd_q, cmd_d;
   logic            cv_q, cv_d;
   logic            ill_q, ill_d;
   logic            fd_q, fd_d;
   logic [6:0]      pix_q, pix_d;
   logic [PIX_W-1:0] rd_q;
   logic [PIX_W-1:0] mem_q [NPIX];

   logic       f_push, f_pop, f_full, f_empty;
   logic [3:0] f_head;
   logic       accept, cap;

   // in_ready is held low while reset is asserted, not just after it
   assign bus.in_ready = !reset && !f_full && state_q != S_FINISHED;
   assign accept = bus.in_valid && bus.in_ready;
   assign f_push = accept && is_legal(bus.in_cmd);
   assign f_pop  = state_q == S_WAIT_RDY && !bus.busy && !f_empty;
   assign cap    = state_q == S_WAIT_DONE && !bus.done && bus.IRAM_valid;

   lcd_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(4)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (f_push),
      .din   (bus.in_cmd),
      .pop   (f_pop),
      .dout  (f_head),
      .full  (f_full),
      .empty (f_empty)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cv_d    = 1'b0;
      fd_d    = 1'b0;
      ill_d   = accept && !is_legal(bus.in_cmd);
      pix_d   = pix_q;
      unique case (state_q)
         S_WAIT_RDY: if (f_pop) begin
            cmd_d   = f_head;
            cv_d    = 1'b1;
            state_d = S_ISSUE;
         end
         S_ISSUE: state_d = (cmd_q == CMD_WRITE) ? S_WAIT_DONE : S_GAP;
         // controller raises busy one cycle after the strobe
         S_GAP: state_d = S_WAIT_RDY;
         S_WAIT_DONE: begin
            if (bus.done) begin
               fd_d    = 1'b1;
               state_d = S_FINISHED;
            end else if (cap && pix_q != 7'd127) begin
               pix_d = pix_q + 7'd1;
            end
         end
         S_FINISHED: state_d = S_FINISHED;
         default: state_d = S_WAIT_RDY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_WAIT_RDY;
         cmd_q   <= '0;
         cv_q    <= 1'b0;
         ill_q   <= 1'b0;
         fd_q    <= 1'b0;
         pix_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cv_q    <= cv_d;
         ill_q   <= ill_d;
         fd_q    <= fd_d;
         pix_q   <= pix_d;
         rd_q    <= mem_q[bus.rd_addr];
      end
   end

   // frame store survives reset
   always_ff @(posedge clk) begin
      if (cap) mem_q[bus.IRAM_A] <= bus.IRAM_D;
   end

   assign bus.cmd         = cmd_q;
   assign bus.cmd_valid   = cv_q;
   assign bus.illegal_cmd = ill_q;
   assign bus.frame_done  = fd_q;
   assign bus.pix_cnt     = pix_q;
   assign bus.rd_data     = rd_q;
endmodule

// File: tb/tb_lcd_host_seq.sv
// Directed bench for lcd_host_seq with an issue-order scoreboard.
module tb_lcd_host_seq;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic [3:0] sb_q[$];
   int   cv_times[$];
   int   issued = 0;

   lcd_host_seq_if #(.PIX_W(8), .ADDR_W(6)) bus ();

   lcd_host_seq #(.CMD_DEPTH(8), .PIX_W(8), .ADDR_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // scoreboard: every strobe must match the oldest accepted opcode
   always @(negedge clk) begin
      if (!reset && bus.cmd_valid === 1'b1) begin
         issued++;
         cv_times.push_back(cyc);
         if (sb_q.size() == 0) chk("sb_underflow", int'(bus.cmd), -1);
         else chk("sb_cmd", int'(bus.cmd), int'(sb_q.pop_front()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] c, output logic acc);
      bus.in_cmd   = c;
      bus.in_valid = 1'b1;
      #1;
      acc = bus.in_ready;
      if (acc && c <= 4'd11) sb_q.push_back(c);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_cv(input string tag, input int max);
      int found = 0;
      for (int i = 0; i < max && found == 0; i++) begin
         step();
         if (bus.cmd_valid === 1'b1) found = 1;
      end
      chk(tag, found, 1);
   endtask

   task automatic wait_sb(input string tag, input int max);
      for (int i = 0; i < max && sb_q.size() != 0; i++) step();
      repeat (3) step();
      chk(tag, sb_q.size(), 0);
   endtask

   initial begin
      logic acc;
      int   cnt;
      reset          = 1'b1;
      bus.in_cmd     = '0;
      bus.in_valid   = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      bus.IRAM_valid = 1'b0;
      bus.IRAM_A     = '0;
      bus.IRAM_D     = '0;
      bus.rd_addr    = '0;
      #2;
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
      chk("rst_cmd", int'(bus.cmd), 0);
      chk("rst_pix_cnt", int'(bus.pix_cnt), 0);
      chk("rst_frame_done", int'(bus.frame_done), 0);
      chk("rst_illegal", int'(bus.illegal_cmd), 0);
      repeat (3) step();
      chk("rst_rd_data", int'(bus.rd_data), 0);
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", int'(bus.in_ready), 1);

      // 1: busy held high blocks issue
      bus.busy = 1'b1;
      push(4'd1, acc);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (bus.cmd_valid === 1'b1) cnt++;
         step();
      end
      chk("t1_no_issue_busy", cnt, 0);
      bus.busy = 1'b0;
      @(negedge clk);
      chk("t1_not_yet", int'(bus.cmd_valid), 0);
      step();
      chk("t1_cv", int'(bus.cmd_valid), 1);
      chk("t1_cmd", int'(bus.cmd), 1);
      step();
      chk("t1_cv_one_cycle", int'(bus.cmd_valid), 0);
      chk("t1_cmd_hold", int'(bus.cmd), 1);
      repeat (3) step();

      // 2: fill FIFO while busy, ninth push refused
      bus.busy = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         push(4'(k), acc);
         if (acc) cnt++;
         if (k == 8) chk("t2_full_ready", int'(bus.in_ready), 0);
      end
      chk("t2_accepted", cnt, 8);
      issued = 0;
      bus.busy = 1'b0;
      wait_sb("t2_drain", 60);
      chk("t2_issued", issued, 8);

      // 3: back-to-back issue pacing
      cv_times.delete();
      push(4'd4, acc);
      push(4'd4, acc);
      push(4'd5, acc);
      wait_sb("t3_drain", 30);
      chk("t3_count", cv_times.size(), 3);
      if (cv_times.size() == 3) begin
         chk("t3_gap1", cv_times[1] - cv_times[0], 3);
         chk("t3_gap2", cv_times[2] - cv_times[1], 3);
      end

      // 5: illegal opcode discarded
      issued = 0;
      push(4'd13, acc);
      chk("t5_illegal_pulse", int'(bus.illegal_cmd), 1);
      step();
      chk("t5_illegal_clear", int'(bus.illegal_cmd), 0);
      repeat (5) step();
      chk("t5_no_issue", issued, 0);

      // 4: full frame capture
      push(4'd0, acc);
      wait_cv("t4_write_issue", 10);
      bus.busy = 1'b1;
      step();
      for (int k = 0; k < 64; k++) begin
         bus.IRAM_valid = 1'b1;
         bus.IRAM_A     = 6'(k);
         bus.IRAM_D     = 8'(k + 100);
         step();
      end
      bus.IRAM_valid = 1'b0;
      chk("t4_pix_before_done", int'(bus.pix_cnt), 64);
      bus.done = 1'b1;
      step();
      chk("t4_frame_done", int'(bus.frame_done), 1);
      step();
      chk("t4_frame_done_pulse", int'(bus.frame_done), 0);
      chk("t4_pix_cnt", int'(bus.pix_cnt), 64);
      chk("t4_in_ready", int'(bus.in_ready), 0);
      bus.IRAM_valid = 1'b1;
      bus.IRAM_A     = 6'd5;
      bus.IRAM_D     = 8'd0;
      bus.rd_addr    = 6'd63;
      step();
      bus.IRAM_valid = 1'b0;
      chk("t4_rd63", int'(bus.rd_data), 163);
      bus.rd_addr = 6'd5;
      step();
      chk("t4_rd5_after_done", int'(bus.rd_data), 105);
      chk("t4_pix_frozen", int'(bus.pix_cnt), 64);
      chk("t4_cv_finished", int'(bus.cmd_valid), 0);

      // 6: reset in the middle of a stream
      reset = 1'b1;
      bus.done = 1'b0;
      bus.busy = 1'b0;
      step();
      reset = 1'b0;
      step();
      push(4'd0, acc);
      wait_cv("t6_write_issue", 10);
      bus.busy = 1'b1;
      step();
      for (int k = 0; k < 20; k++) begin
         bus.IRAM_valid = 1'b1;
         bus.IRAM_A     = 6'(k);
         bus.IRAM_D     = 8'(k + 100);
         step();
      end
      chk("t6_pix_pre", int'(bus.pix_cnt), 20);
      bus.IRAM_A = 6'd20;
      bus.IRAM_D = 8'd120;
      reset = 1'b1;
      #1;
      chk("t6_async_pix", int'(bus.pix_cnt), 0);
      chk("t6_async_cv", int'(bus.cmd_valid), 0);
      chk("t6_async_ready", int'(bus.in_ready), 0);
      bus.IRAM_valid = 1'b0;
      bus.busy = 1'b0;
      step();
      reset = 1'b0;
      bus.rd_addr = 6'd19;
      step();
      chk("t6_mem19", int'(bus.rd_data), 119);
      chk("t6_ready", int'(bus.in_ready), 1);
      issued = 0;
      push(4'd2, acc);
      wait_sb("t6_issue_after", 10);
      chk("t6_issued", issued, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
